// File: rtl/ecg_sample_streamer.sv
// ecg_sample_streamer: single-frame ECG sample buffer that replays the frame
// as LANES-wide beats, each beat held for two clocks (first clock, capture clock).
module ecg_sample_streamer #(
    parameter int unsigned DW    = 17,
    parameter int unsigned DEPTH = 800,
    parameter int unsigned LANES = 8,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          Enable,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    input  logic          start_stream,
    input  logic          stream_ready,
    output logic [DW-1:0] data_out1,
    output logic [DW-1:0] data_out2,
    output logic [DW-1:0] data_out3,
    output logic [DW-1:0] data_out4,
    output logic [DW-1:0] data_out5,
    output logic [DW-1:0] data_out6,
    output logic [DW-1:0] data_out7,
    output logic [DW-1:0] data_out8,
    output logic          out_valid,
    output logic          out_phase,
    output logic [AW-1:0] beat_base,
    output logic          frame_full,
    output logic          frame_done,
    output logic          overrun
);

    // Buffer index width: just enough to address DEPTH entries.
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0] LAST_WR   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_BASE = AW'(DEPTH - LANES);
    localparam logic [AW-1:0] BEAT_STEP = AW'(LANES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        FULL   = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [AW-1:0] wp;
    logic [AW-1:0] wp_d;
    logic [AW-1:0] base_d;
    logic          phase_d;
    logic          valid_d;
    logic          full_d;
    logic          done_d;
    logic          overrun_d;
    logic          we_c;
    logic          load_c;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] lanes   [LANES];
    logic [DW-1:0] lanes_d [LANES];

    // Frame storage; contents survive reset and Enable low.
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[IW'(wp)] <= sample_in;
        end
    end

    // Gather the LANES samples of the beat that starts at the next base index.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            lanes_d[i] = mem[IW'(base_d + AW'(i))];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        wp_d      = wp;
        base_d    = beat_base;
        phase_d   = out_phase;
        valid_d   = out_valid;
        full_d    = frame_full;
        done_d    = 1'b0;
        overrun_d = overrun;
        we_c      = 1'b0;
        load_c    = 1'b0;

        case (state)
            IDLE: begin
                valid_d = 1'b0;
                full_d  = 1'b0;
                if (sample_valid) begin
                    we_c    = 1'b1;
                    wp_d    = AW'(1);
                    state_d = FILL;
                end
            end

            FILL: begin
                if (sample_valid) begin
                    we_c = 1'b1;
                    wp_d = wp + AW'(1);
                    if (wp == LAST_WR) begin
                        full_d  = 1'b1;
                        state_d = FULL;
                    end
                end
            end

            FULL: begin
                full_d = 1'b1;
                if (sample_valid) begin
                    overrun_d = 1'b1;
                end
                if (start_stream) begin
                    state_d = STREAM;
                    base_d  = '0;
                    phase_d = 1'b0;
                    valid_d = 1'b1;
                    load_c  = 1'b1;
                end
            end

            STREAM: begin
                valid_d = 1'b1;
                if (sample_valid) begin
                    overrun_d = 1'b1;
                end
                if (stream_ready) begin
                    if (!out_phase) begin
                        phase_d = 1'b1;
                    end else if (beat_base == LAST_BASE) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        full_d  = 1'b0;
                        done_d  = 1'b1;
                        wp_d    = '0;
                        base_d  = '0;
                        phase_d = 1'b0;
                    end else begin
                        base_d  = beat_base + BEAT_STEP;
                        phase_d = 1'b0;
                        load_c  = 1'b1;
                    end
                end
            end

            DONE: begin
                valid_d = 1'b0;
                full_d  = 1'b0;
                wp_d    = '0;
                if (sample_valid) begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                full_d  = 1'b0;
                wp_d    = '0;
                base_d  = '0;
                phase_d = 1'b0;
            end
        endcase
    end

    // State and control registers; Enable low clears them like reset.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            wp         <= '0;
            beat_base  <= '0;
            out_phase  <= 1'b0;
            out_valid  <= 1'b0;
            frame_full <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else if (!Enable) begin
            state      <= IDLE;
            wp         <= '0;
            beat_base  <= '0;
            out_phase  <= 1'b0;
            out_valid  <= 1'b0;
            frame_full <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            wp         <= wp_d;
            beat_base  <= base_d;
            out_phase  <= phase_d;
            out_valid  <= valid_d;
            frame_full <= full_d;
            frame_done <= done_d;
            overrun    <= overrun_d;
        end
    end

    // Lane registers, reloaded only when a new beat begins.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < int'(LANES); i++) begin
                lanes[i] <= '0;
            end
        end else if (!Enable) begin
            for (int i = 0; i < int'(LANES); i++) begin
                lanes[i] <= '0;
            end
        end else if (load_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                lanes[i] <= lanes_d[i];
            end
        end
    end

    assign data_out1 = lanes[0];
    assign data_out2 = lanes[1];
    assign data_out3 = lanes[2];
    assign data_out4 = lanes[3];
    assign data_out5 = lanes[4];
    assign data_out6 = lanes[5];
    assign data_out7 = lanes[6];
    assign data_out8 = lanes[7];

endmodule

// File: tb/tb_ecg_sample_streamer.sv
// Directed bench for ecg_sample_streamer: fills, replays, backpressure,
// overrun, gapped signed input, Enable clear and asynchronous reset.
module tb_ecg_sample_streamer;

    localparam int DW    = 17;
    localparam int DEPTH = 800;
    localparam int LANES = 8;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          nReset;
    logic          Enable;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic          start_stream;
    logic          stream_ready;
    logic [DW-1:0] data_out1, data_out2, data_out3, data_out4;
    logic [DW-1:0] data_out5, data_out6, data_out7, data_out8;
    logic          out_valid;
    logic          out_phase;
    logic [AW-1:0] beat_base;
    logic          frame_full;
    logic          frame_done;
    logic          overrun;
    logic [DW-1:0] lanes [LANES];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          en;
        logic          sv;
        logic [DW-1:0] din;
        logic          start;
        logic          rdy;
        logic          exp_valid;
        logic          exp_full;
        logic          exp_done;
        logic          exp_ovr;
        logic [AW-1:0] exp_base;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    ecg_sample_streamer dut (
        .clk          (clk),
        .nReset       (nReset),
        .Enable       (Enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .start_stream (start_stream),
        .stream_ready (stream_ready),
        .data_out1    (data_out1),
        .data_out2    (data_out2),
        .data_out3    (data_out3),
        .data_out4    (data_out4),
        .data_out5    (data_out5),
        .data_out6    (data_out6),
        .data_out7    (data_out7),
        .data_out8    (data_out8),
        .out_valid    (out_valid),
        .out_phase    (out_phase),
        .beat_base    (beat_base),
        .frame_full   (frame_full),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    assign lanes[0] = data_out1;
    assign lanes[1] = data_out2;
    assign lanes[2] = data_out3;
    assign lanes[3] = data_out4;
    assign lanes[4] = data_out5;
    assign lanes[5] = data_out6;
    assign lanes[6] = data_out7;
    assign lanes[7] = data_out8;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample value expected at buffer index idx for a given fill pattern.
    function automatic logic [DW-1:0] expv(input int kind, input int idx);
        if (kind == 1) begin
            return (idx % 2 == 0) ? 17'h1FFFB : 17'd5;
        end
        return DW'(idx);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_phase"}, 32'(out_phase), 32'd0);
        check({tag, "_base"},  32'(beat_base), 32'd0);
        check({tag, "_full"},  32'(frame_full), 32'd0);
        check({tag, "_done"},  32'(frame_done), 32'd0);
        check({tag, "_ovr"},   32'(overrun), 32'd0);
        for (int j = 0; j < LANES; j++) begin
            check($sformatf("%s_lane%0d", tag, j), 32'(lanes[j]), 32'd0);
        end
    endtask

    // Write DEPTH samples, with gap idle clocks between writes.
    task automatic fill(input int kind, input int gap);
        for (int i = 0; i < DEPTH; i++) begin
            sample_valid = 1'b1;
            sample_in    = expv(kind, i);
            step();
            sample_valid = 1'b0;
            check($sformatf("full_after_wr%0d", i), 32'(frame_full), (i == DEPTH - 1) ? 32'd1 : 32'd0);
            for (int g = 0; g < gap; g++) step();
        end
        sample_in = '0;
    endtask

    // Replay the frame against a beat model; optional 5-clock stall at base 16 phase 1.
    task automatic stream(input int kind, input bit bp, input int exp_clocks);
        int eb = 0;
        int ep = 0;
        int hold = 0;
        int beats = 0;
        int cyc;
        bit fin = 1'b0;
        bit rdy;
        start_stream = 1'b1;
        step();
        start_stream = 1'b0;
        cyc = 1;
        while (!fin && cyc < 400) begin
            check($sformatf("valid@%0d", eb), 32'(out_valid), 32'd1);
            check($sformatf("base@%0d", eb), 32'(beat_base), 32'(eb));
            check($sformatf("phase@%0d", eb), 32'(out_phase), 32'(ep));
            check($sformatf("done@%0d", eb), 32'(frame_done), 32'd0);
            for (int j = 0; j < LANES; j++) begin
                check($sformatf("lane%0d@%0d", j, eb), 32'(lanes[j]), 32'(expv(kind, eb + j)));
            end
            rdy = !(bp && eb == 16 && ep == 1 && hold < 5);
            if (!rdy) hold++;
            stream_ready = rdy;
            step();
            cyc++;
            if (rdy) begin
                if (ep == 0) begin
                    ep = 1;
                end else begin
                    beats++;
                    if (eb == DEPTH - LANES) fin = 1'b1;
                    else begin
                        eb += LANES;
                        ep = 0;
                    end
                end
            end
        end
        stream_ready = 1'b1;
        check("stream_finished", 32'(fin), 32'd1);
        check("stream_beats", 32'(beats), 32'd100);
        check("stream_done_clock", 32'(cyc), 32'(exp_clocks));
        check("done_pulse", 32'(frame_done), 32'd1);
        check("done_valid", 32'(out_valid), 32'd0);
        check("done_full", 32'(frame_full), 32'd0);
        step();
        check("done_single", 32'(frame_done), 32'd0);
        check("after_done_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Post-reset protocol vectors: start requests outside FULL are ignored.
        vecs[0] = '{1'b1, 1'b0, 17'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
        vecs[1] = '{1'b1, 1'b0, 17'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
        vecs[2] = '{1'b1, 1'b1, 17'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
        vecs[3] = '{1'b1, 1'b0, 17'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
        vecs[4] = '{1'b1, 1'b1, 17'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
        vecs[5] = '{1'b0, 1'b1, 17'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
        vecs[6] = '{1'b1, 1'b0, 17'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};

        nReset       = 1'b0;
        Enable       = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        start_stream = 1'b0;
        stream_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        nReset = 1'b1;
        step();

        // Fill with k, overrun pulse, full replay.
        fill(0, 0);
        check("ovr_before", 32'(overrun), 32'd0);
        sample_valid = 1'b1;
        sample_in    = 17'h1ABCD;
        step();
        sample_valid = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_full_held", 32'(frame_full), 32'd1);
        step();
        check("ovr_sticky", 32'(overrun), 32'd1);
        stream(0, 1'b0, 201);
        check("ovr_after_done", 32'(overrun), 32'd1);

        // Gapped signed fill, replay with backpressure.
        fill(1, 2);
        stream(1, 1'b1, 206);

        // Enable low mid-stream at beat_base 400.
        fill(0, 0);
        start_stream = 1'b1;
        step();
        start_stream = 1'b0;
        for (int n = 0; n < 200 && beat_base != 12'd400; n++) step();
        check("en_base_reached", 32'(beat_base), 32'd400);
        check("en_ovr_still_set", 32'(overrun), 32'd1);
        Enable = 1'b0;
        step();
        check_idle_outputs("enlow");
        Enable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            check($sformatf("enlow_no_done%0d", n), 32'(frame_done), 32'd0);
            check($sformatf("enlow_no_valid%0d", n), 32'(out_valid), 32'd0);
        end
        fill(0, 0);
        stream(0, 1'b0, 201);

        // Asynchronous reset between edges during STREAM.
        fill(0, 0);
        start_stream = 1'b1;
        step();
        start_stream = 1'b0;
        repeat (3) step();
        check("pre_areset_valid", 32'(out_valid), 32'd1);
        #3;
        nReset = 1'b0;
        #1;
        check_idle_outputs("areset");
        @(posedge clk);
        #1;
        nReset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            Enable       = vecs[v].en;
            sample_valid = vecs[v].sv;
            sample_in    = vecs[v].din;
            start_stream = vecs[v].start;
            stream_ready = vecs[v].rdy;
            step();
            check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_full", v), 32'(frame_full), 32'(vecs[v].exp_full));
            check($sformatf("vec%0d_done", v), 32'(frame_done), 32'(vecs[v].exp_done));
            check($sformatf("vec%0d_ovr", v), 32'(overrun), 32'(vecs[v].exp_ovr));
            check($sformatf("vec%0d_base", v), 32'(beat_base), 32'(vecs[v].exp_base));
        end
        Enable       = 1'b1;
        sample_valid = 1'b0;
        start_stream = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ecg_sample_streamer.md
Name: ecg_sample_streamer

Overview:
- Frame buffer and burst transmitter that feeds the 8-lane sample bus of the wavelet and max/min cores.
- Accepts one 17-bit ECG sample per valid cycle from the acquisition front end and stores one frame of DEPTH samples.
- Once the frame is full, replays it as LANES consecutive samples per beat, with each beat held for two clocks to match the downstream alternate-cycle capture.
- Raises frame_done after the last beat so the next frame can be loaded.

Parameters:
- DW, 17, sample width in bits (signed two's complement).
- DEPTH, 800, samples per frame. Must be a multiple of LANES.
- LANES, 8, samples presented per beat.
- AW, 12, address and index width.

Ports:
- clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- Enable  input  1  block enable; when low, the block is synchronously cleared.
- sample_in  input  DW  incoming sample.
- sample_valid  input  1  sample_in is valid this cycle.
- start_stream  input  1  one-cycle request to replay the buffered frame.
- stream_ready  input  1  downstream can accept the current beat.
- data_out1..data_out8  output  DW each  lanes 1..8, holding samples base..base+7.
- out_valid  output  1  data_out lanes are valid.
- out_phase  output  1  0 on the first clock of a beat, 1 on the second (capture) clock.
- beat_base  output  AW  index of the sample on data_out1.
- frame_full  output  1  the buffer holds a complete frame.
- frame_done  output  1  one-cycle pulse after the last beat is accepted.
- overrun  output  1  sticky flag; a sample arrived while the block could not store it.

Behaviour:
- Reset (nReset low, asynchronous): state IDLE; all outputs 0; write pointer wp and beat_base 0. Buffer contents are don't-care and are not cleared.
- Enable low at a clock edge: same values as reset, applied synchronously; buffer contents are retained.
- States are IDLE, FILL, FULL, STREAM, DONE.
- IDLE:
  - sample_valid -> write buffer[0], wp=1, go to FILL.
- FILL:
  - Each sample_valid writes buffer[wp] and increments wp.
  - A write with wp==DEPTH-1 sets frame_full on the next cycle and moves to FULL.
  - No wrap-around.
- FULL:
  - frame_full=1.
  - start_stream -> go to STREAM with beat_base=0, out_phase=0, out_valid=1 on the next cycle.
  - start_stream in any other state is ignored.
- STREAM:
  - data_outN = buffer[beat_base+N-1], registered. out_valid stays 1 for the whole state.
  - out_phase toggles 0 -> 1 only while stream_ready=1. If stream_ready=0, the lanes, out_phase and beat_base all hold.
  - A beat completes on a clock with out_phase=1 and stream_ready=1:
    - if beat_base==DEPTH-LANES, go to DONE;
    - otherwise beat_base += LANES and out_phase=0.
  - Minimum frame replay time is 2*DEPTH/LANES clocks (200 at defaults).
- DONE:
  - One cycle with frame_done=1, out_valid=0, frame_full=0, wp=0; then go to IDLE.
- Simultaneous events:
  - sample_valid in FULL, STREAM or DONE is dropped and sets overrun=1.
  - overrun clears only on reset or Enable low.
  - sample_valid in the DONE cycle is dropped; the next frame begins with the first valid sample in IDLE.
- Data path:
  - Samples are passed through unmodified; no sign extension or saturation.
  - Index arithmetic is AW-bit unsigned; DEPTH-1 must fit in AW bits.
- Reset mid-STREAM: out_valid drops immediately (asynchronously) and no frame_done is issued.

Test Plan:
- Fill and stream: reset; write samples with value k for k=0..799, one per clock; assert start_stream -> frame_full=1 after the 800th write. Beat 0 shows data_out1..8 = 0..7 and beat 99 shows 792..799. Each beat lasts exactly 2 clocks, frame_done pulses once at clock 201 after start, and there are 100 beats in total.
- Backpressure: hold stream_ready=0 for 5 clocks while out_phase=1 at beat_base=16 -> lanes stay at 16..23, beat_base stays 16, out_phase stays 1; streaming resumes when ready returns.
- Overrun: after frame_full, pulse sample_valid with value 0x1ABCD -> overrun=1 and stays set. Replayed sample 0 still equals 0, and overrun remains set after frame_done.
- Gapped input: sample_valid asserted every third cycle with signed values alternating -5 and +5 -> data_out values match, including negative values 0x1FFFB, and frame_full rises only after the 800th valid sample.
- Enable low mid-stream at beat_base=400 -> on the next clock out_valid=0, state IDLE, beat_base=0, and frame_done is never pulsed. A fresh 800-sample fill works afterward.
- Asynchronous reset pulse between clock edges during STREAM -> all outputs 0 immediately. start_stream in IDLE is ignored and out_valid stays 0.
